// File: rtl/bcd2_cascade_ctr.sv
// Two-digit BCD up/down counter stepped by an upstream prescaler tick, with
// clamped parallel load and registered wrap pulses. Define BCD_SATURATE_EN to saturate instead of wrap.
module bcd2_cascade_ctr #(
  parameter int MAX_UNITS = 9,
  parameter int MAX_TENS  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_units,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       carry_out,
  output logic       borrow_out,
  output logic       tc
);

  localparam logic [3:0] MU = 4'(MAX_UNITS);
  localparam logic [3:0] MT = 4'(MAX_TENS);

  logic at_max, at_zero, step;

  assign at_max  = (tens == MT) && (units == MU);
  assign at_zero = (tens == 4'd0) && (units == 4'd0);
  assign step    = en && tick_in;
  assign tc      = en && (up ? at_max : at_zero);

  always_ff @(posedge clk) begin
    if (rst) begin
      tens       <= 4'd0;
      units      <= 4'd0;
      carry_out  <= 1'b0;
      borrow_out <= 1'b0;
    end else begin
      // pulses default low so every wrap pulse is exactly one cycle wide
      carry_out  <= 1'b0;
      borrow_out <= 1'b0;
      if (load) begin
        tens  <= (load_tens  > MT) ? MT : load_tens;
        units <= (load_units > MU) ? MU : load_units;
      end else if (step) begin
        if (up) begin
          if (units != MU) begin
            units <= units + 4'd1;
          end else if (tens != MT) begin
            units <= 4'd0;
            tens  <= tens + 4'd1;
          end else begin
`ifdef BCD_SATURATE_EN
            units <= MU;
            tens  <= MT;
`else
            units     <= 4'd0;
            tens      <= 4'd0;
            carry_out <= 1'b1;
`endif
          end
        end else begin
          if (units != 4'd0) begin
            units <= units - 4'd1;
          end else if (tens != 4'd0) begin
            units <= MU;
            tens  <= tens - 4'd1;
          end else begin
`ifdef BCD_SATURATE_EN
            units <= 4'd0;
            tens  <= 4'd0;
`else
            units      <= MU;
            tens       <= MT;
            borrow_out <= 1'b1;
`endif
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd2_cascade_ctr.sv
// Bench for bcd2_cascade_ctr: directed vector table, corner sequences, and
// random stimulus against a linear-count reference model.
module tb_bcd2_cascade_ctr;
  localparam int MU = 9;
  localparam int MT = 5;
  localparam int N  = (MT + 1) * (MU + 1);

  logic       clk = 1'b0;
  logic       rst, tick_in, en, up, load;
  logic [3:0] load_tens, load_units, tens, units;
  logic       carry_out, borrow_out, tc;

  bcd2_cascade_ctr #(.MAX_UNITS(MU), .MAX_TENS(MT)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .en(en), .up(up), .load(load),
    .load_tens(load_tens), .load_units(load_units), .tens(tens), .units(units),
    .carry_out(carry_out), .borrow_out(borrow_out), .tc(tc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r, ld, e, t, u;
    logic [3:0] lt, lu;
    logic [3:0] et, eu;
    logic       ec, eb, etc_;
  } vec_t;

  int   checks = 0;
  int   passes = 0;
  int   mv = 0;       // model count as a single integer 0..N-1
  logic mc = 1'b0, mb = 1'b0;

  function automatic vec_t mk(logic r, logic ld, logic e, logic t, logic u,
                              int lt, int lu, int et, int eu, logic ec, logic eb, logic etc_);
    vec_t x;
    x.r = r; x.ld = ld; x.e = e; x.t = t; x.u = u;
    x.lt = 4'(lt); x.lu = 4'(lu); x.et = 4'(et); x.eu = 4'(eu);
    x.ec = ec; x.eb = eb; x.etc_ = etc_;
    return x;
  endfunction

  function automatic logic [10:0] pack(logic [3:0] t, logic [3:0] u, logic c, logic b, logic k);
    return {t, u, c, b, k};
  endfunction

  function automatic logic [10:0] model_out();
    logic k;
    k = en && (up ? (mv == N - 1) : (mv == 0));
    return pack(4'(mv / (MU + 1)), 4'(mv % (MU + 1)), mc, mb, k);
  endfunction

  task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0d:%0d c=%0b b=%0b tc=%0b, expected %0d:%0d c=%0b b=%0b tc=%0b",
                  name, got[10:7], got[6:3], got[2], got[1], got[0],
                  exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
  endtask

  // Drive one cycle of inputs, advance the reference model, sample after the edge.
  task automatic drive(input logic r, input logic ld, input logic e, input logic t,
                       input logic u, input logic [3:0] lt, input logic [3:0] lu);
    int ct, cu;
    rst = r; load = ld; en = e; tick_in = t; up = u; load_tens = lt; load_units = lu;
    mc = 1'b0; mb = 1'b0;
    if (r) mv = 0;
    else if (ld) begin
      ct = (int'(lt) > MT) ? MT : int'(lt);
      cu = (int'(lu) > MU) ? MU : int'(lu);
      mv = ct * (MU + 1) + cu;
    end else if (e && t) begin
      if (u) begin
        if (mv < N - 1) mv++;
`ifndef BCD_SATURATE_EN
        else begin mv = 0; mc = 1'b1; end
`endif
      end else begin
        if (mv > 0) mv--;
`ifndef BCD_SATURATE_EN
        else begin mv = N - 1; mb = 1'b1; end
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] dut_out();
    return pack(tens, units, carry_out, borrow_out, tc);
  endfunction

  vec_t tbl[18];

  initial begin
    rst = 1'b1; load = 1'b0; en = 1'b0; tick_in = 1'b0; up = 1'b0;
    load_tens = 4'd0; load_units = 4'd0;

    //            r  ld e  t  u  lt  lu  et eu ec eb tc
    tbl[0]  = mk(1, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 0, 0, 1, 5,  8,  5, 8, 0, 0, 0);
    tbl[4]  = mk(0, 0, 1, 1, 1, 0,  0,  5, 9, 0, 0, 1);
`ifdef BCD_SATURATE_EN
    tbl[5]  = mk(0, 0, 1, 1, 1, 0,  0,  5, 9, 0, 0, 1);
    tbl[6]  = mk(0, 0, 1, 1, 0, 0,  0,  5, 8, 0, 0, 0);
    tbl[7]  = mk(0, 0, 1, 1, 0, 0,  0,  5, 7, 0, 0, 0);
`else
    tbl[5]  = mk(0, 0, 1, 1, 1, 0,  0,  0, 0, 1, 0, 0);
    tbl[6]  = mk(0, 0, 1, 1, 0, 0,  0,  5, 9, 0, 1, 0);
    tbl[7]  = mk(0, 0, 1, 1, 0, 0,  0,  5, 8, 0, 0, 0);
`endif
    tbl[8]  = mk(0, 1, 1, 1, 1, 4,  7,  4, 7, 0, 0, 0);
    tbl[9]  = mk(0, 0, 1, 1, 1, 0,  0,  4, 8, 0, 0, 0);
    tbl[10] = mk(0, 1, 0, 0, 1, 7, 12,  5, 9, 0, 0, 0);
    tbl[11] = mk(0, 1, 1, 1, 1, 15, 15, 5, 9, 0, 0, 1);
    tbl[12] = mk(0, 0, 1, 0, 1, 0,  0,  5, 9, 0, 0, 1);
    tbl[13] = mk(0, 0, 1, 1, 0, 0,  0,  5, 8, 0, 0, 0);
    tbl[14] = mk(0, 1, 1, 1, 0, 1,  0,  1, 0, 0, 0, 0);
    tbl[15] = mk(0, 0, 1, 1, 0, 0,  0,  0, 9, 0, 0, 0);
    tbl[16] = mk(0, 0, 1, 1, 0, 0,  0,  0, 8, 0, 0, 0);
    tbl[17] = mk(0, 1, 1, 0, 0, 0,  0,  0, 0, 0, 0, 1);

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].r, tbl[i].ld, tbl[i].e, tbl[i].t, tbl[i].u, tbl[i].lt, tbl[i].lu);
      check($sformatf("vec%0d", i), dut_out(),
            pack(tbl[i].et, tbl[i].eu, tbl[i].ec, tbl[i].eb, tbl[i].etc_));
    end

    // en low with ticks present: ten edges of hold
    drive(0, 1, 0, 0, 1, 4'd2, 4'd3);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 1, 1, 4'd0, 4'd0);
      check($sformatf("hold%0d", i), dut_out(), pack(4'd2, 4'd3, 1'b0, 1'b0, 1'b0));
    end

    // reset while counting
    drive(0, 1, 1, 0, 1, 4'd3, 4'd3);
    drive(0, 0, 1, 1, 1, 4'd0, 4'd0);
    check("cnt_3_4", dut_out(), pack(4'd3, 4'd4, 1'b0, 1'b0, 1'b0));
    drive(1, 0, 1, 1, 1, 4'd0, 4'd0);
    check("rst_mid", dut_out(), pack(4'd0, 4'd0, 1'b0, 1'b0, 1'b0));

    // reset landing on an active carry pulse
    drive(0, 1, 1, 0, 1, 4'd5, 4'd9);
    drive(0, 0, 1, 1, 1, 4'd0, 4'd0);
`ifdef BCD_SATURATE_EN
    check("up_at_max", dut_out(), pack(4'd5, 4'd9, 1'b0, 1'b0, 1'b1));
`else
    check("carry_wrap", dut_out(), pack(4'd0, 4'd0, 1'b1, 1'b0, 1'b0));
`endif
    drive(1, 0, 1, 1, 1, 4'd0, 4'd0);
    check("rst_carry", dut_out(), pack(4'd0, 4'd0, 1'b0, 1'b0, 1'b0));

    // down at zero then straight back up: consecutive wrap pulses
    drive(0, 0, 1, 1, 0, 4'd0, 4'd0);
`ifdef BCD_SATURATE_EN
    check("down_at_zero", dut_out(), pack(4'd0, 4'd0, 1'b0, 1'b0, 1'b1));
    drive(0, 0, 1, 1, 1, 4'd0, 4'd0);
    check("up_from_zero", dut_out(), pack(4'd0, 4'd1, 1'b0, 1'b0, 1'b0));
`else
    check("borrow_wrap", dut_out(), pack(4'd5, 4'd9, 1'b0, 1'b1, 1'b0));
    drive(0, 0, 1, 1, 1, 4'd0, 4'd0);
    check("b2b_carry", dut_out(), pack(4'd0, 4'd0, 1'b1, 1'b0, 1'b0));
`endif

    // random traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      check($sformatf("rand%0d", i), dut_out(), model_out());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
